// File: rtl/hdmi_period_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_period_scheduler
// Function : Per-pixel HDMI period sequencer (control / video / data island)
//            with packet-picker strobes, in the clk_pixel domain.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_period_scheduler #(
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int DVI_OUTPUT    = 0
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  output logic [2:0]            mode,
  output logic                  packet_enable,
  output logic [4:0]            packet_pixel_counter,
  output logic                  video_field_end,
  output logic [4:0]            island_packet_index
);

  localparam logic [2:0] c_CTRL      = 3'd0;
  localparam logic [2:0] c_VID_DATA  = 3'd1;
  localparam logic [2:0] c_VID_GUARD = 3'd2;
  localparam logic [2:0] c_ISL_DATA  = 3'd3;
  localparam logic [2:0] c_ISL_GUARD = 3'd4;
  localparam logic [2:0] c_VID_PRE   = 3'd5;
  localparam logic [2:0] c_ISL_PRE   = 3'd6;

  localparam int c_NUM_AVAIL   = (FRAME_WIDTH - SCREEN_WIDTH - 40) / 32;
  localparam int c_NUM_PACKETS = (c_NUM_AVAIL > 18) ? 18 : c_NUM_AVAIL;
  localparam bit c_DVI         = (DVI_OUTPUT != 0);

  localparam logic [BIT_WIDTH-1:0]  c_ONE_X       = BIT_WIDTH'(1);
  localparam logic [BIT_HEIGHT-1:0] c_ONE_Y       = BIT_HEIGHT'(1);
  localparam logic [BIT_WIDTH-1:0]  c_ISL_START   = BIT_WIDTH'(SCREEN_WIDTH + 4);
  localparam logic [BIT_WIDTH-1:0]  c_VID_START   = BIT_WIDTH'(FRAME_WIDTH - 10);
  localparam logic [BIT_WIDTH-1:0]  c_LINE_LAST   = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0]  c_VDATA_LAST  = BIT_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0]  c_PRE_LAST    = BIT_WIDTH'(7);
  localparam logic [BIT_WIDTH-1:0]  c_GUARD_LAST  = BIT_WIDTH'(1);
  localparam logic [BIT_WIDTH-1:0]  c_DATA_LAST   = BIT_WIDTH'(32 * c_NUM_PACKETS - 1);
  localparam logic [BIT_WIDTH-1:0]  c_LAST_PKT    = BIT_WIDTH'(32 * (c_NUM_PACKETS - 1));
  localparam logic [BIT_HEIGHT-1:0] c_SH          = BIT_HEIGHT'(SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT-1:0] c_VFE_Y       = BIT_HEIGHT'(SCREEN_HEIGHT - 1);
  localparam logic [BIT_HEIGHT-1:0] c_FRAME_LAST  = BIT_HEIGHT'(FRAME_HEIGHT - 1);

  generate
    if (DVI_OUTPUT == 0 && c_NUM_PACKETS < 1) begin : g_num_packets_check
      $error("hdmi_period_scheduler: horizontal blanking too short for a data island");
    end
  endgenerate

  logic [2:0]            r_state;
  logic [BIT_WIDTH-1:0]  r_cnt;
  logic                  r_tail;
  logic [BIT_WIDTH-1:0]  r_prev_cx;
  logic                  r_packet_enable;
  logic [4:0]            r_ppc;
  logic [4:0]            r_idx;
  logic                  r_vfe;

  logic [2:0]            w_state;
  logic [BIT_WIDTH-1:0]  w_cnt;
  logic                  w_tail;
  logic [BIT_WIDTH-1:0]  w_cx_expect;
  logic [BIT_HEIGHT-1:0] w_cy_next;
  logic                  w_next_active;
  logic                  w_in_data;
  logic                  w_pe;
  logic [4:0]            w_ppc;
  logic [4:0]            w_idx;
  logic                  w_vfe;

  assign w_cx_expect   = (r_prev_cx == c_LINE_LAST) ? '0 : r_prev_cx + c_ONE_X;
  assign w_cy_next     = (cy == c_FRAME_LAST) ? '0 : cy + c_ONE_Y;
  assign w_next_active = (w_cy_next < c_SH);

  // r_cnt is the 0-based pixel index within the current period
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + c_ONE_X;
    w_tail  = r_tail;
    if (r_state != c_CTRL && cx != w_cx_expect) begin
      w_state = c_CTRL;
      w_cnt   = '0;
      w_tail  = 1'b0;
    end else begin
      case (r_state)
        c_CTRL: begin
          w_cnt  = '0;
          w_tail = 1'b0;
          if (c_DVI) begin
            if (cx == '0 && cy < c_SH) w_state = c_VID_DATA;
          end else if (cx == c_ISL_START) begin
            w_state = c_ISL_PRE;
          end else if (cx == c_VID_START && w_next_active) begin
            w_state = c_VID_PRE;
          end
        end
        c_ISL_PRE: if (r_cnt == c_PRE_LAST) begin
          w_state = c_ISL_GUARD;
          w_cnt   = '0;
        end
        c_ISL_GUARD: if (r_cnt == c_GUARD_LAST) begin
          w_cnt   = '0;
          w_state = r_tail ? c_CTRL : c_ISL_DATA;
          w_tail  = 1'b0;
        end
        c_ISL_DATA: if (r_cnt == c_DATA_LAST) begin
          w_state = c_ISL_GUARD;
          w_cnt   = '0;
          w_tail  = 1'b1;
        end
        c_VID_PRE: if (r_cnt == c_PRE_LAST) begin
          w_state = c_VID_GUARD;
          w_cnt   = '0;
        end
        c_VID_GUARD: if (r_cnt == c_GUARD_LAST) begin
          w_state = c_VID_DATA;
          w_cnt   = '0;
        end
        c_VID_DATA: if (r_cnt == c_VDATA_LAST) begin
          w_state = c_CTRL;
          w_cnt   = '0;
        end
        default: begin
          w_state = c_CTRL;
          w_cnt   = '0;
          w_tail  = 1'b0;
        end
      endcase
    end
  end

  assign w_in_data = (w_state == c_ISL_DATA);
  assign w_ppc     = w_in_data ? w_cnt[4:0] : 5'd0;
  assign w_idx     = w_in_data ? 5'(w_cnt >> 5)
                   : (w_state == c_ISL_GUARD && w_tail) ? r_idx : 5'd0;
  // One strobe ahead of every packet: last leading guard, then each packet end but the final one
  assign w_pe      = !c_DVI &&
                     ((w_state == c_ISL_GUARD && !w_tail && w_cnt == c_GUARD_LAST) ||
                      (w_in_data && w_cnt[4:0] == 5'd31 && w_cnt < c_LAST_PKT));
  assign w_vfe     = (cx == c_VDATA_LAST) && (cy == c_VFE_Y);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= c_CTRL;
      r_cnt           <= '0;
      r_tail          <= 1'b0;
      r_prev_cx       <= '0;
      r_packet_enable <= 1'b0;
      r_ppc           <= 5'd0;
      r_idx           <= 5'd0;
      r_vfe           <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_cnt           <= w_cnt;
      r_tail          <= w_tail;
      r_prev_cx       <= cx;
      r_packet_enable <= w_pe;
      r_ppc           <= w_ppc;
      r_idx           <= w_idx;
      r_vfe           <= w_vfe;
    end
  end

  assign mode                 = r_state;
  assign packet_enable        = r_packet_enable;
  assign packet_pixel_counter = r_ppc;
  assign video_field_end      = r_vfe;
  assign island_packet_index  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_period_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_period_scheduler
// Function : Scoreboard bench for hdmi_period_scheduler (HDMI and DVI builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_period_scheduler;

  localparam int c_SW = 640;
  localparam int c_SH = 480;
  localparam int c_FW = 800;
  localparam int c_FH = 525;
  localparam int c_NP = 3;
  localparam int c_D0 = c_SW + 14;

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b0;
  logic [9:0] cx        = '0;
  logic [9:0] cy        = '0;

  logic [2:0] w_mode, w_dvi_mode;
  logic       w_pe, w_dvi_pe, w_vfe, w_dvi_vfe;
  logic [4:0] w_ppc, w_dvi_ppc, w_idx, w_dvi_idx;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_period_scheduler #(
    .BIT_WIDTH(10), .BIT_HEIGHT(10), .SCREEN_WIDTH(c_SW), .SCREEN_HEIGHT(c_SH),
    .FRAME_WIDTH(c_FW), .FRAME_HEIGHT(c_FH), .DVI_OUTPUT(0)
  ) u_dut_hdmi (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .cx(cx), .cy(cy),
    .mode(w_mode), .packet_enable(w_pe), .packet_pixel_counter(w_ppc),
    .video_field_end(w_vfe), .island_packet_index(w_idx)
  );

  hdmi_period_scheduler #(
    .BIT_WIDTH(10), .BIT_HEIGHT(10), .SCREEN_WIDTH(c_SW), .SCREEN_HEIGHT(c_SH),
    .FRAME_WIDTH(c_FW), .FRAME_HEIGHT(c_FH), .DVI_OUTPUT(1)
  ) u_dut_dvi (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .cx(cx), .cy(cy),
    .mode(w_dvi_mode), .packet_enable(w_dvi_pe), .packet_pixel_counter(w_dvi_ppc),
    .video_field_end(w_dvi_vfe), .island_packet_index(w_dvi_idx)
  );

  typedef struct {
    int         x;
    int         y;
    logic [2:0] mode;
    logic       pe;
    logic [4:0] ppc;
    logic [4:0] idx;
    logic       vfe;
    logic [2:0] dvi_mode;
    bit         loose;
    bit         chk_idx;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pe_seen = 0;
  int   vfe_seen = 0;
  int   dvi_vfe_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected outputs for one input pixel, straight from the period map
  function automatic exp_t model(input int x, input int y, input bit loose);
    exp_t e;
    int   ny;
    bit   in_data;
    ny      = (y + 1) % c_FH;
    in_data = (x >= c_D0) && (x < c_D0 + 32 * c_NP);
    e.x = x;
    e.y = y;
    e.loose = loose;
    if (x < c_SW && y < c_SH)                             e.mode = 3'd1;
    else if (x >= c_SW + 4 && x <= c_SW + 11)             e.mode = 3'd6;
    else if (x == c_SW + 12 || x == c_SW + 13)            e.mode = 3'd4;
    else if (in_data)                                     e.mode = 3'd3;
    else if (x >= c_D0 + 32 * c_NP && x < c_D0 + 32 * c_NP + 2) e.mode = 3'd4;
    else if (ny < c_SH && x >= c_FW - 10 && x <= c_FW - 3) e.mode = 3'd5;
    else if (ny < c_SH && x >= c_FW - 2)                  e.mode = 3'd2;
    else                                                  e.mode = 3'd0;
    e.pe = (x == c_SW + 13) ||
           (x >= c_D0 && x < c_D0 + 32 * (c_NP - 1) && ((x - c_D0) % 32) == 31);
    e.ppc      = in_data ? 5'((x - c_D0) % 32) : 5'd0;
    e.idx      = in_data ? 5'((x - c_D0) / 32) : 5'd0;
    e.chk_idx  = !(x >= c_D0 + 32 * c_NP && x < c_D0 + 32 * c_NP + 2);
    e.vfe      = (x == c_SW - 1) && (y == c_SH - 1);
    e.dvi_mode = (x < c_SW && y < c_SH) ? 3'd1 : 3'd0;
    return e;
  endfunction

  task automatic compare_pending();
    exp_t  e;
    string at;
    if (q.size() != 0) begin
      e  = q.pop_front();
      at = $sformatf("@(%0d,%0d)", e.x, e.y);
      if (e.loose) begin
        tests++;
        assert (w_mode === 3'd0 || w_mode === 3'd1) else begin
          fails++;
          $error("FAIL mode_resync%s observed=%0d expected=0or1", at, w_mode);
        end
        tests++;
        assert (w_dvi_mode === 3'd0 || w_dvi_mode === 3'd1) else begin
          fails++;
          $error("FAIL dvi_mode_resync%s observed=%0d expected=0or1", at, w_dvi_mode);
        end
      end else begin
        check({"mode", at}, 32'(w_mode), 32'(e.mode));
        check({"dvi_mode", at}, 32'(w_dvi_mode), 32'(e.dvi_mode));
      end
      check({"packet_enable", at}, 32'(w_pe), 32'(e.pe));
      check({"dvi_packet_enable", at}, 32'(w_dvi_pe), 32'd0);
      check({"packet_pixel_counter", at}, 32'(w_ppc), 32'(e.ppc));
      check({"video_field_end", at}, 32'(w_vfe), 32'(e.vfe));
      check({"dvi_video_field_end", at}, 32'(w_dvi_vfe), 32'(e.vfe));
      if (e.chk_idx) check({"island_packet_index", at}, 32'(w_idx), 32'(e.idx));
      if (w_pe === 1'b1) pe_seen++;
      if (w_vfe === 1'b1) vfe_seen++;
      if (w_dvi_vfe === 1'b1) dvi_vfe_seen++;
    end
  endtask

  task automatic step(input int x, input int y, input bit loose);
    @(negedge clk_pixel);
    compare_pending();
    cx = 10'(x);
    cy = 10'(y);
    q.push_back(model(x, y, loose));
  endtask

  task automatic sweep(input int y, input int x0, input int x1, input bit loose);
    for (int x = x0; x <= x1; x++) step(x, y, loose);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mode"}, 32'(w_mode), 32'd0);
    check({tag, "_packet_enable"}, 32'(w_pe), 32'd0);
    check({tag, "_packet_pixel_counter"}, 32'(w_ppc), 32'd0);
    check({tag, "_video_field_end"}, 32'(w_vfe), 32'd0);
    check({tag, "_island_packet_index"}, 32'(w_idx), 32'd0);
    check({tag, "_dvi_mode"}, 32'(w_dvi_mode), 32'd0);
    check({tag, "_dvi_packet_enable"}, 32'(w_dvi_pe), 32'd0);
    check({tag, "_dvi_packet_pixel_counter"}, 32'(w_dvi_ppc), 32'd0);
    check({tag, "_dvi_video_field_end"}, 32'(w_dvi_vfe), 32'd0);
    check({tag, "_dvi_island_packet_index"}, 32'(w_dvi_idx), 32'd0);
  endtask

  initial begin
    cx = 10'd789;
    cy = 10'd9;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_pixel);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Prime the video preamble from the previous line, then a full reference line
    sweep(9, 790, 799, 1'b0);
    pe_seen = 0;
    sweep(10, 0, 799, 1'b0);
    check("line10_packet_enable_count", 32'(pe_seen), 32'd3);

    // Frame boundary lines: last active, first blank, vertical wrap
    vfe_seen = 0;
    dvi_vfe_seen = 0;
    sweep(478, 0, 799, 1'b0);
    sweep(479, 0, 799, 1'b0);
    sweep(480, 0, 799, 1'b0);
    sweep(523, 0, 799, 1'b0);
    sweep(524, 0, 799, 1'b0);
    sweep(0, 0, 799, 1'b0);

    // Position discontinuity in the middle of the island
    sweep(1, 0, 700, 1'b0);
    pe_seen = 0;
    sweep(1, 100, 639, 1'b1);
    sweep(2, 640, 799, 1'b0);
    check("video_field_end_count", 32'(vfe_seen), 32'd1);
    check("dvi_video_field_end_count", 32'(dvi_vfe_seen), 32'd1);
    check("packet_enable_after_jump", 32'(pe_seen), 32'd3);

    // Asynchronous reset in the middle of the island
    sweep(3, 0, 700, 1'b0);
    @(posedge clk_pixel);
    #1;
    compare_pending();
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    q.delete();
    @(negedge clk_pixel);
    cx = 10'd751;
    cy = 10'd3;
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;
    sweep(3, 752, 799, 1'b0);
    pe_seen = 0;
    sweep(4, 0, 799, 1'b0);
    @(negedge clk_pixel);
    compare_pending();
    check("line4_packet_enable_count", 32'(pe_seen), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
